// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIF 8-point FFT datapath stages.
package fft_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 50;
  localparam int unsigned HALF_WIDTH     = DATA_WIDTH_DEF / 2;
  localparam int unsigned FRAME_LEN      = 8;
  localparam int unsigned NUM_BFLY       = 4;
  localparam int unsigned IDX_W          = 3;

  typedef struct packed {
    logic signed [HALF_WIDTH-1:0] re;
    logic signed [HALF_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Upper input index of each stage-2 butterfly, issue order p = 0..3.
  localparam logic [NUM_BFLY-1:0][IDX_W-1:0] STAGE2_IDX = {3'd5, 3'd4, 3'd1, 3'd0};

  // Odd upper indices (1, 5) take the W4^1 = -j twiddle.
  function automatic logic is_negj(input logic [IDX_W-1:0] idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/fft_cplx_addsub.sv
// Multiplier-free complex butterfly: a+b and (a-b)*w with w in {1, -j},
// optionally scaled by 1/2 with floor rounding.
module fft_cplx_addsub
  import fft_pkg::*;
#(
  parameter int unsigned HW    = HALF_WIDTH,
  parameter bit          SCALE = 1'b0
) (
  input  logic [2*HW-1:0] a_i,
  input  logic [2*HW-1:0] b_i,
  input  logic            rot_negj_i,
  output logic [2*HW-1:0] sum_o,
  output logic [2*HW-1:0] diff_o
);

  localparam int unsigned EW = HW + 1;

  logic [EW-1:0] a_re, a_im, b_re, b_im;
  logic [EW-1:0] s_re, s_im, d_re, d_im;
  logic [EW-1:0] r_re, r_im;

  // One guard bit keeps the exact result so the scaled path can floor-halve it.
  function automatic logic [HW-1:0] fit(input logic [EW-1:0] v);
    return SCALE ? v[HW:1] : v[HW-1:0];
  endfunction

  always_comb begin
    a_re = {a_i[2*HW-1], a_i[2*HW-1:HW]};
    a_im = {a_i[HW-1], a_i[HW-1:0]};
    b_re = {b_i[2*HW-1], b_i[2*HW-1:HW]};
    b_im = {b_i[HW-1], b_i[HW-1:0]};

    s_re = a_re + b_re;
    s_im = a_im + b_im;
    d_re = a_re - b_re;
    d_im = a_im - b_im;

    // (a+jb)*(-j) = b - ja; negation happens before any scaling.
    r_re = rot_negj_i ? d_im : d_re;
    r_im = rot_negj_i ? (EW'(0) - d_re) : d_im;

    sum_o  = {fit(s_re), fit(s_im)};
    diff_o = {fit(r_re), fit(r_im)};
  end

endmodule

// File: rtl/fft_butterfly_stage2.sv
// Stage-2 radix-2 DIF butterflies of the 8-point FFT: buffers one frame,
// runs four swap/negate butterflies through one pipeline register, then streams it out.
module fft_butterfly_stage2
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          SCALE      = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int unsigned HW        = DATA_WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] ISSUE_END = IDX_W'(NUM_BFLY);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0]        issue_q, issue_d;

  logic                    pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]        pipe_idx_q, pipe_idx_d;
  logic [DATA_WIDTH-1:0]   pipe_sum_q, pipe_sum_d;
  logic [DATA_WIDTH-1:0]   pipe_diff_q, pipe_diff_d;

  logic [DATA_WIDTH-1:0]   in_buf_q  [FRAME_LEN];
  logic [DATA_WIDTH-1:0]   in_buf_d  [FRAME_LEN];
  logic [DATA_WIDTH-1:0]   out_buf_q [FRAME_LEN];
  logic [DATA_WIDTH-1:0]   out_buf_d [FRAME_LEN];

  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   signal_q, signal_d;

  logic [IDX_W-1:0]        bf_a_idx, bf_b_idx, pipe_idx_b, rd_nxt;
  logic [DATA_WIDTH-1:0]   bf_sum, bf_diff;

  assign bf_a_idx   = STAGE2_IDX[issue_q[1:0]];
  assign bf_b_idx   = bf_a_idx + IDX_W'(2);
  assign pipe_idx_b = pipe_idx_q + IDX_W'(2);
  assign rd_nxt     = rd_cnt_q + IDX_W'(1);

  fft_cplx_addsub #(
    .HW    (HW),
    .SCALE (SCALE)
  ) u_addsub (
    .a_i        (in_buf_q[bf_a_idx]),
    .b_i        (in_buf_q[bf_b_idx]),
    .rot_negj_i (is_negj(bf_a_idx)),
    .sum_o      (bf_sum),
    .diff_o     (bf_diff)
  );

  // Next-state, buffer and output logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    issue_d     = issue_q;
    pipe_vld_d  = 1'b0;
    pipe_idx_d  = pipe_idx_q;
    pipe_sum_d  = pipe_sum_q;
    pipe_diff_d = pipe_diff_q;
    in_buf_d    = in_buf_q;
    out_buf_d   = out_buf_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    last_d      = last_q;
    signal_d    = signal_q;

    if (pipe_vld_q) begin
      out_buf_d[pipe_idx_q] = pipe_sum_q;
      out_buf_d[pipe_idx_b] = pipe_diff_q;
    end

    case (state_q)
      ST_FILL: begin
        if (valid_i && ready_q) begin
          in_buf_d[wr_cnt_q] = signal_i;
          wr_cnt_d           = wr_cnt_q + IDX_W'(1);
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = ST_COMPUTE;
            wr_cnt_d = '0;
            issue_d  = '0;
            ready_d  = 1'b0;
          end
        end
      end

      ST_COMPUTE: begin
        if (issue_q < ISSUE_END) begin
          pipe_vld_d  = 1'b1;
          pipe_idx_d  = bf_a_idx;
          pipe_sum_d  = bf_sum;
          pipe_diff_d = bf_diff;
          issue_d     = issue_q + IDX_W'(1);
        end else begin
          // Flush cycle: y[0] was written long ago, present it now.
          state_d  = ST_DRAIN;
          rd_cnt_d = '0;
          valid_d  = 1'b1;
          last_d   = 1'b0;
          signal_d = out_buf_q[0];
        end
      end

      ST_DRAIN: begin
        if (valid_q && ready_i) begin
          if (rd_cnt_q == LAST_IDX) begin
            state_d  = ST_FILL;
            rd_cnt_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            ready_d  = 1'b1;
          end else begin
            rd_cnt_d = rd_nxt;
            signal_d = out_buf_q[rd_nxt];
            last_d   = (rd_nxt == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = ST_FILL;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      issue_q    <= '0;
      pipe_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      signal_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      issue_q    <= issue_d;
      pipe_vld_q <= pipe_vld_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      signal_q   <= signal_d;
    end
  end

  // Data storage carries no reset; stale contents are never presented.
  always_ff @(posedge clk_i) begin
    in_buf_q    <= in_buf_d;
    out_buf_q   <= out_buf_d;
    pipe_idx_q  <= pipe_idx_d;
    pipe_sum_q  <= pipe_sum_d;
    pipe_diff_q <= pipe_diff_d;
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign signal_o = signal_q;

endmodule

// File: tb/tb_fft_butterfly_stage2.sv
// Bench for fft_butterfly_stage2: wrapping and scaling instances share one stimulus stream.
module tb_fft_butterfly_stage2;
  import fft_pkg::*;

  localparam int unsigned DW = DATA_WIDTH_DEF;
  localparam int unsigned HW = HALF_WIDTH;

  typedef cplx_t [7:0] frame_t;
  typedef struct packed {
    frame_t x;
    frame_t y0;
    frame_t y1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i;
  logic [DW-1:0] sig_i;
  logic          rdy0, vld0, last0, rdy1, vld1, last1;
  logic [DW-1:0] sig0, sig1;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  fft_butterfly_stage2 #(.DATA_WIDTH(DW), .SCALE(1'b0)) u_s0 (
    .clk_i(clk), .rst_i(rst_i), .signal_i(sig_i), .valid_i(valid_i), .ready_o(rdy0),
    .signal_o(sig0), .valid_o(vld0), .ready_i(ready_i), .last_o(last0)
  );

  fft_butterfly_stage2 #(.DATA_WIDTH(DW), .SCALE(1'b1)) u_s1 (
    .clk_i(clk), .rst_i(rst_i), .signal_i(sig_i), .valid_i(valid_i), .ready_o(rdy1),
    .signal_o(sig1), .valid_o(vld1), .ready_i(ready_i), .last_o(last1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer butterflies, then floor-halve (scaled) or keep the low H bits (wrapped).
  function automatic longint fin(input longint v, input bit sc);
    return sc ? (v >>> 1) : v;
  endfunction

  function automatic frame_t model(input frame_t x, input bit sc);
    frame_t y;
    longint ar, ai, br, bi, sr, si, dr, di, t;
    int i;
    y = '0;
    for (int b = 0; b < 4; b++) begin
      i  = (b < 2) ? b : b + 2;
      ar = longint'(x[i].re);
      ai = longint'(x[i].im);
      br = longint'(x[i+2].re);
      bi = longint'(x[i+2].im);
      sr = ar + br;
      si = ai + bi;
      dr = ar - br;
      di = ai - bi;
      if (i == 1 || i == 5) begin
        t  = dr;
        dr = di;
        di = -t;
      end
      y[i].re   = HW'(fin(sr, sc));
      y[i].im   = HW'(fin(si, sc));
      y[i+2].re = HW'(fin(dr, sc));
      y[i+2].im = HW'(fin(di, sc));
    end
    return y;
  endfunction

  function automatic logic [HW-1:0] rand_half();
    case ($urandom_range(0, 5))
      0:       return 25'h1000000;
      1:       return 25'h0FFFFFF;
      2:       return 25'h0;
      3:       return 25'h1FFFFFF;
      default: return HW'($urandom);
    endcase
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f[k].re = rand_half();
      f[k].im = rand_half();
    end
    return f;
  endfunction

  task automatic send_frame(input frame_t x, input bit gaps, input bit junk_after);
    int w;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          valid_i = 1'b0;
          sig_i   = DW'({$urandom, $urandom});
          step();
        end
      end
      valid_i = 1'b1;
      sig_i   = x[k];
      w = 0;
      while (!rdy0 && w < 50) begin
        step();
        w++;
      end
      chk($sformatf("ready_o fill k=%0d", k), 64'(rdy0 & rdy1), 64'd1);
      chk($sformatf("valid_o fill k=%0d", k), 64'(vld0 | vld1), 64'd0);
      step();
    end
    valid_i = junk_after;
    sig_i   = DW'({$urandom, $urandom});
  endtask

  task automatic recv_frame(input frame_t e0, input frame_t e1, input int n_take,
                            input int stall_at, input int stall_len,
                            input bit rand_stall, input bit junk);
    int w;
    int st;
    w = 0;
    while (!vld0 && w < 40) begin
      chk("ready_o compute", 64'(rdy0 | rdy1), 64'd0);
      ready_i = 1'($urandom);
      if (junk) begin
        valid_i = 1'b1;
        sig_i   = DW'({$urandom, $urandom});
      end
      step();
      w++;
    end
    chk("latency to y0", 64'(w), 64'd5);
    for (int k = 0; k < n_take; k++) begin
      st = (k == stall_at) ? stall_len : (rand_stall ? $urandom_range(0, 2) : 0);
      repeat (st) begin
        ready_i = 1'b0;
        chk($sformatf("held y%0d s0", k), 64'(sig0), 64'(e0[k]));
        chk($sformatf("held y%0d s1", k), 64'(sig1), 64'(e1[k]));
        chk($sformatf("held valid y%0d", k), 64'(vld0 & vld1), 64'd1);
        chk($sformatf("held last y%0d", k), 64'(last0), 64'(k == 7));
        chk($sformatf("held ready_o y%0d", k), 64'(rdy0 | rdy1), 64'd0);
        step();
      end
      ready_i = 1'b1;
      chk($sformatf("y%0d s0", k), 64'(sig0), 64'(e0[k]));
      chk($sformatf("y%0d s1", k), 64'(sig1), 64'(e1[k]));
      chk($sformatf("valid y%0d", k), 64'(vld0 & vld1), 64'd1);
      chk($sformatf("last s0 y%0d", k), 64'(last0), 64'(k == 7));
      chk($sformatf("last s1 y%0d", k), 64'(last1), 64'(k == 7));
      chk($sformatf("ready_o drain y%0d", k), 64'(rdy0 | rdy1), 64'd0);
      if (k == 7) valid_i = 1'b0;
      else if (junk) begin
        valid_i = 1'b1;
        sig_i   = DW'({$urandom, $urandom});
      end
      step();
    end
    if (n_take == 8) begin
      chk("ready_o after frame", 64'(rdy0 & rdy1), 64'd1);
      chk("valid_o after frame", 64'(vld0 | vld1), 64'd0);
      chk("last_o after frame", 64'(last0 | last1), 64'd0);
    end
  endtask

  vec_t   vecs[6];
  frame_t fr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    sig_i   = '0;
    repeat (3) step();
    chk("reset ready_o", 64'(rdy0 & rdy1), 64'd1);
    chk("reset valid_o", 64'(vld0 | vld1), 64'd0);
    chk("reset last_o", 64'(last0 | last1), 64'd0);
    chk("reset signal_o s0", 64'(sig0), 64'd0);
    chk("reset signal_o s1", 64'(sig1), 64'd0);
    rst_i = 1'b0;
    step();
    chk("idle ready_o", 64'(rdy0 & rdy1), 64'd1);
    chk("idle valid_o", 64'(vld0 | vld1), 64'd0);

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // Impulse at x[0]
    vecs[0].x[0].re  = 25'd1;
    vecs[0].y0[0].re = 25'd1;
    vecs[0].y0[2].re = 25'd1;
    // Rotation of x[1] by -j
    vecs[1].x[1].re  = 25'd1;
    vecs[1].y0[1].re = 25'd1;
    vecs[1].y0[3].im = 25'h1FFFFFF;
    vecs[1].y1[3].im = 25'h1FFFFFF;
    // Rotation of x[5] = 3j
    vecs[2].x[5].im  = 25'd3;
    vecs[2].y0[5].im = 25'd3;
    vecs[2].y0[7].re = 25'd3;
    vecs[2].y1[5].im = 25'd1;
    vecs[2].y1[7].re = 25'd1;
    // Positive overflow: wrap versus halve
    vecs[3].x[0].re  = 25'h0FFFFFF;
    vecs[3].x[2].re  = 25'd1;
    vecs[3].y0[0].re = 25'h1000000;
    vecs[3].y0[2].re = 25'h0FFFFFE;
    vecs[3].y1[0].re = 25'h0800000;
    vecs[3].y1[2].re = 25'h07FFFFF;
    // Negating the most negative value through the -j twiddle
    vecs[4].x[1].re  = 25'h1000000;
    vecs[4].y0[1].re = 25'h1000000;
    vecs[4].y0[3].im = 25'h1000000;
    vecs[4].y1[1].re = 25'h1800000;
    vecs[4].y1[3].im = 25'h0800000;
    // Unrotated butterfly (4,6) with mixed signs
    vecs[5].x[4].re  = 25'd2;
    vecs[5].x[4].im  = 25'd5;
    vecs[5].x[6].re  = 25'd3;
    vecs[5].x[6].im  = 25'h1FFFFFF;
    vecs[5].y0[4].re = 25'd5;
    vecs[5].y0[4].im = 25'd4;
    vecs[5].y0[6].re = 25'h1FFFFFF;
    vecs[5].y0[6].im = 25'd6;
    vecs[5].y1[4].re = 25'd2;
    vecs[5].y1[4].im = 25'd2;
    vecs[5].y1[6].re = 25'h1FFFFFF;
    vecs[5].y1[6].im = 25'd3;

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].x, 1'b0, 1'b0);
      recv_frame(vecs[i].y0, vecs[i].y1, 8, -1, 0, 1'b0, 1'b0);
    end

    // Backpressure: hold y[2] for three cycles
    fr = rand_frame();
    send_frame(fr, 1'b0, 1'b0);
    recv_frame(model(fr, 1'b0), model(fr, 1'b1), 8, 2, 3, 1'b0, 1'b0);

    // Upstream gaps plus junk offered while ready_o is low
    fr = rand_frame();
    send_frame(fr, 1'b1, 1'b1);
    recv_frame(model(fr, 1'b0), model(fr, 1'b1), 8, -1, 0, 1'b0, 1'b1);

    // Reset after y[3] is accepted, then a clean frame
    fr = rand_frame();
    send_frame(fr, 1'b0, 1'b0);
    recv_frame(model(fr, 1'b0), model(fr, 1'b1), 4, -1, 0, 1'b0, 1'b0);
    ready_i = 1'b0;
    valid_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid-drain reset valid_o", 64'(vld0 | vld1), 64'd0);
    chk("mid-drain reset ready_o", 64'(rdy0 & rdy1), 64'd1);
    chk("mid-drain reset last_o", 64'(last0 | last1), 64'd0);
    chk("mid-drain reset signal_o", 64'(sig0 | sig1), 64'd0);
    fr = rand_frame();
    send_frame(fr, 1'b0, 1'b0);
    recv_frame(model(fr, 1'b0), model(fr, 1'b1), 8, -1, 0, 1'b0, 1'b0);

    // Randomized frames with random gaps, stalls and blocked junk
    for (int n = 0; n < 25; n++) begin
      bit j;
      j  = 1'($urandom);
      fr = rand_frame();
      send_frame(fr, 1'($urandom), j);
      recv_frame(model(fr, 1'b0), model(fr, 1'b1), 8, -1, 0, 1'b1, j);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
